hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. It watches the instruction held in IF_ID and the instruction currently in EX, and drives the stall and flush controls for PC, IF_ID and ID_EX. It handles three cases: load-use interlock, taken-branch/jump redirect, and FENCE drain. The drain uses a small FSM with a down-counter. The block sits beside the ID stage and the immediate generator and sequences what enters ID_EX.

## Interface
- DRAIN_CYCLES, 3: total stall cycles a FENCE spends in ID before release; legal range 2..15.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_instr  in  32  IF_ID Instr_Out.
- id_valid  in  1  IF_ID holds a real instruction (not a bubble).
- ex_valid  in  1  ID_EX holds a real instruction.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- br_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF_ID contents.
- if_id_flush  out  1  load a bubble into IF_ID (id_valid=0 next cycle).
- id_ex_flush  out  1  load a bubble into ID_EX.
- stall_cycles  out  32  perf counter (see Configuration).
- flush_events  out  32  perf counter (see Configuration).

## Operation
- Field decode from id_instr: opcode=[6:0], rs1=[19:15], rs2=[24:20].
- rs1 is used for these opcodes:
  - 0010011 (OP-IMM)
  - 0000011 (LOAD)
  - 0100011 (STORE)
  - 1100011 (BRANCH)
  - 0110011 (OP)
  - 1100111 (JALR)
- rs2 is used for 0110011, 0100011 and 1100011.
- LUI, AUIPC, JAL, FENCE and SYSTEM use neither rs1 nor rs2.
- lu_hit = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)).
- fence_id = id_valid & opcode==0001111.
- FSM states: RUN, DRAIN, RELEASE. Counter cnt is 4 bits.
- Priority, highest first: br_taken, then drain, then load-use.
- br_taken=1, any state:
  - Outputs: if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0.
  - Next state: RUN, cnt<=0.
- RUN, fence_id=1:
  - Outputs: pc_stall=if_id_stall=id_ex_flush=1.
  - Next state: DRAIN, cnt<=DRAIN_CYCLES-1.
- RUN, lu_hit=1:
  - Outputs: pc_stall=if_id_stall=id_ex_flush=1.
  - Stays in RUN. The interlock costs exactly one bubble because the load moves to MEM.
- RUN, otherwise: all controls 0.
- DRAIN:
  - Outputs: pc_stall=if_id_stall=id_ex_flush=1.
  - If cnt==1, next state is RELEASE; else cnt<=cnt-1.
- RELEASE:
  - All controls 0; the FENCE advances into ID_EX.
  - Next state: RUN.
  - RELEASE exists so the FENCE is not re-detected when it passes.
- if_id_stall always equals pc_stall.
- if_id_flush and if_id_stall are never both 1.

## Timing
- Outputs are combinational: a function of the registered state/cnt and same-cycle inputs. Zero-cycle latency from input to control.
- FENCE accepted at cycle T: stall high for cycles T..T+DRAIN_CYCLES-1, RELEASE at T+DRAIN_CYCLES.
- br_taken during DRAIN or RELEASE aborts the drain: the FENCE is younger and is flushed. It is never released.
- br_taken together with lu_hit: flush wins and no stall is issued.
- lu_hit in DRAIN has no extra effect because the stall is already asserted. lu_hit is not evaluated in RELEASE; the FENCE has no sources.
- Reset, asynchronous: state=RUN, cnt=0, perf counters=0.
- While rst_n=0, all four control outputs are forced to 0.
- Reset asserted mid-DRAIN returns to RUN immediately, with no RELEASE cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_stall=1.
  - flush_events increments on every cycle with br_taken=1.
  - Both saturate at 32'hFFFF_FFFF and clear only on reset.
- HAZARD_PERF_CNT_EN undefined:
  - No counter registers are built.
  - stall_cycles and flush_events are tied to 32'h0.

## Test plan
- Load-use: EX has lw x5 (ex_mem_read=1, ex_rd=5), ID has add x6,x5,x7 (0x00728333) -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then all 0. Repeat with ex_rd=0 -> no stall.
- No false hazard: ID has lui x5 (0x000052B7) or jal, EX has a load to x5 -> no stall. ID has sw x5,0(x6) with rs2=x5 -> stall.
- FENCE drain with DRAIN_CYCLES=3: ID has 0x0FF0000F at cycle T -> stall at T..T+2, RELEASE at T+3 with all controls 0, back to RUN at T+4; stall_cycles reads 3 with the macro defined.
- Branch abort: br_taken=1 at T+1 of a FENCE drain -> if_id_flush=id_ex_flush=1 and pc_stall=0 that cycle, state RUN next; flush_events reads 1.
- Simultaneous br_taken and lu_hit -> flush only, no stall. rst_n low mid-DRAIN -> outputs 0 immediately; RUN after deassert, with counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core.
//
// Watches the instruction in IF_ID and the instruction in EX and drives the
// stall/flush controls for PC, IF_ID and ID_EX. Three cases are handled, from
// highest priority to lowest:
//   1. taken branch/jump redirect (flush IF_ID and ID_EX),
//   2. FENCE drain (a RUN/DRAIN/RELEASE FSM with a 4-bit down-counter),
//   3. load-use interlock (one bubble into ID_EX).
//
// Parameters:
//   DRAIN_CYCLES  total stall cycles a FENCE spends in ID (legal 2..15)
//
// Ports:
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   id_instr      instruction held in IF_ID
//   id_valid      IF_ID holds a real instruction
//   ex_valid      ID_EX holds a real instruction
//   ex_mem_read   instruction in EX is a load
//   ex_rd         destination register of the instruction in EX
//   br_taken      EX resolved a taken branch/JAL/JALR this cycle
//   pc_stall      hold PC
//   if_id_stall   hold IF_ID (always equal to pc_stall)
//   if_id_flush   load a bubble into IF_ID
//   id_ex_flush   load a bubble into ID_EX
//   stall_cycles  perf counter: cycles with pc_stall=1
//   flush_events  perf counter: cycles with br_taken=1
//
// Configuration macro:
//   HAZARD_PERF_CNT_EN  when defined, builds the two saturating perf counters;
//                       otherwise stall_cycles/flush_events are tied to zero.

module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        br_taken,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpFence  = 7'b0001111;

    // The FENCE cycle in RUN counts as the first stall cycle.
    localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StRelease
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Decode of the instruction in ID
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       lu_hit;
    logic       fence_id;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    // Remaining instruction bits carry no hazard information.
    logic unused_id_bits;
    assign unused_id_bits = ^{id_instr[31:25], id_instr[14:7]};

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OpOpImm, OpLoad, OpJalr: rs1_used = 1'b1;
            OpStore, OpBranch, OpOp: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign lu_hit = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));

    assign fence_id = id_valid & (opcode == OpFence);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic stall_c;
    logic if_flush_c;
    logic ex_flush_c;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_c    = 1'b0;
        if_flush_c = 1'b0;
        ex_flush_c = 1'b0;

        if (br_taken) begin
            // Redirect wins over everything; an in-flight FENCE is younger
            // than the branch and is discarded, so the drain is abandoned.
            if_flush_c = 1'b1;
            ex_flush_c = 1'b1;
            state_d    = StRun;
            cnt_d      = 4'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (fence_id) begin
                        stall_c    = 1'b1;
                        ex_flush_c = 1'b1;
                        state_d    = StDrain;
                        cnt_d      = DrainInit;
                    end else if (lu_hit) begin
                        // One bubble suffices: the load reaches MEM next cycle.
                        stall_c    = 1'b1;
                        ex_flush_c = 1'b1;
                    end
                end
                StDrain: begin
                    stall_c    = 1'b1;
                    ex_flush_c = 1'b1;
                    cnt_d      = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    // FENCE still sits in ID this cycle; skipping detection
                    // here lets it pass into ID_EX instead of re-triggering.
                    state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Controls are quiet while reset is held.
    assign pc_stall    = rst_n & stall_c;
    assign if_id_stall = rst_n & stall_c;
    assign if_id_flush = rst_n & if_flush_c;
    assign id_ex_flush = rst_n & ex_flush_c;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'h0;
            flush_events_q <= 32'h0;
        end else begin
            if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (br_taken && (flush_events_q != 32'hFFFF_FFFF)) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = 32'h0;
    assign flush_events = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// stimulus, all checked against a timeline-based reference model.

module tb_hazard_ctrl;

    localparam int unsigned D = 3;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_valid;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        br_taken;
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .DRAIN_CYCLES(D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .br_taken    (br_taken),
        .pc_stall    (pc_stall),
        .if_id_stall (if_id_stall),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a FENCE is tracked by the cycle it was accepted in.
    // It stalls for D cycles in total and is released on the D-th cycle after.
    int          cyc = 0;
    int          fence_start = -1;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b0110011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    // One cycle: inputs already driven; sample at negedge, advance model, step clock.
    // x_stall / x_flush: optional explicit expectations (-1 = none).
    task automatic step(input int x_stall = -1, input int x_flush = -1);
        logic [6:0] op;
        bit lu, fid, e_stall, e_flush;
        @(negedge clk);
        op  = id_instr[6:0];
        lu  = id_valid && ex_valid && ex_mem_read && (ex_rd != 0) &&
              ((reads_rs1(op) && id_instr[19:15] == ex_rd) ||
               (reads_rs2(op) && id_instr[24:20] == ex_rd));
        fid = id_valid && (op == 7'b0001111);
        e_stall = 0;
        e_flush = 0;
        if (!rst_n) begin
            fence_start = -1;
            m_stall = 0;
            m_flush = 0;
        end else if (br_taken) begin
            e_flush = 1;
        end else if (fence_start >= 0) begin
            e_stall = (cyc - fence_start) < int'(D);
        end else begin
            e_stall = fid || lu;
        end

        check_eq("pc_stall", 32'(pc_stall), 32'(e_stall));
        check_eq("if_id_stall", 32'(if_id_stall), 32'(e_stall));
        check_eq("if_id_flush", 32'(if_id_flush), 32'(e_flush));
        check_eq("id_ex_flush", 32'(id_ex_flush), 32'(e_stall | e_flush));
        check_eq("stall_cycles", stall_cycles, Perf ? m_stall : 32'd0);
        check_eq("flush_events", flush_events, Perf ? m_flush : 32'd0);
        if (x_stall >= 0) check_eq("dir_stall", 32'(pc_stall), 32'(x_stall));
        if (x_flush >= 0) check_eq("dir_flush", 32'(if_id_flush), 32'(x_flush));

        if (rst_n) begin
            if (e_stall) m_stall++;
            if (br_taken) m_flush++;
            if (br_taken) fence_start = -1;
            else if (fence_start >= 0) begin
                if ((cyc - fence_start) >= int'(D)) fence_start = -1;
            end else if (fid) fence_start = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_instr    = 32'h0000_0013;
        id_valid    = 1'b0;
        ex_valid    = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        br_taken    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0);
        rst_n = 1'b1;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_mem_read = 1'b1;
        ex_rd       = rd;
    endtask

    logic [6:0] ops [11];

    initial begin
        ops = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111,
                7'b1110011};
        idle();
        rst_n = 1'b0;
        #1;
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);

        // Load-use on rs1, then the load has moved on.
        id_valid = 1'b1;
        id_instr = 32'h0072_8333;
        load_in_ex(5'd5);
        step(1, 0);
        ex_valid = 1'b0;
        ex_mem_read = 1'b0;
        step(0, 0);
        // Load to x0 never interlocks.
        load_in_ex(5'd0);
        id_instr = 32'h0000_0333;
        step(0, 0);
        // No false hazards from LUI / JAL.
        load_in_ex(5'd5);
        id_instr = 32'h0000_52B7;
        step(0, 0);
        id_instr = 32'h0002_80EF;
        step(0, 0);
        // sw x5,0(x6): rs2 hazard.
        id_instr = 32'h0053_2023;
        step(1, 0);

        // FENCE drain from a clean reset.
        idle();
        do_reset();
        id_valid = 1'b1;
        id_instr = 32'h0FF0_000F;
        step(1, 0);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        id_valid = 1'b0;
        step(0, 0);
        check_eq("fence_stall_count", stall_cycles, Perf ? 32'd3 : 32'd0);

        // Branch aborts a drain at T+1.
        do_reset();
        id_valid = 1'b1;
        id_instr = 32'h0FF0_000F;
        step(1, 0);
        br_taken = 1'b1;
        step(0, 1);
        br_taken = 1'b0;
        id_valid = 1'b0;
        step(0, 0);
        check_eq("abort_flush_count", flush_events, Perf ? 32'd1 : 32'd0);

        // Branch together with load-use: flush only.
        id_valid = 1'b1;
        id_instr = 32'h0072_8333;
        load_in_ex(5'd7);
        br_taken = 1'b1;
        step(0, 1);

        // Reset in the middle of a drain.
        idle();
        id_valid = 1'b1;
        id_instr = 32'h0FF0_000F;
        step(1, 0);
        step(1, 0);
        rst_n = 1'b0;
        step(0, 0);
        rst_n = 1'b1;
        id_valid = 1'b0;
        check_eq("rst_stall_cnt_clear", stall_cycles, 32'd0);
        check_eq("rst_flush_cnt_clear", flush_events, 32'd0);
        step(0, 0);

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            id_instr        = $urandom;
            id_instr[6:0]   = ops[$urandom_range(0, 10)];
            id_instr[19:15] = 5'($urandom_range(0, 3));
            id_instr[24:20] = 5'($urandom_range(0, 3));
            id_valid        = ($urandom_range(0, 7) != 0);
            ex_valid        = ($urandom_range(0, 3) != 0);
            ex_mem_read     = ($urandom_range(0, 1) != 0);
            ex_rd           = 5'($urandom_range(0, 3));
            br_taken        = ($urandom_range(0, 11) == 0);
            rst_n           = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
